// File: rtl/mem_access_sequencer.sv
// Memory-stage sequencer: word/byte loads and stores plus two-phase indirect
// accesses over a handshaked memory port, stalling the pipeline until done.
module mem_access_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 16,
   parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   input  logic                  req_write,
   input  logic                  req_byte,
   input  logic                  req_indirect,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  stall,
   output logic [ADDR_WIDTH-1:0] mem_address,
   output logic                  mem_read,
   output logic                  mem_write,
   output logic [BE_WIDTH-1:0]   mem_byte_enable,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata,
   input  logic                  mem_resp
);

   localparam int LSB = $clog2(BE_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BE_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, PTR, ACCESS, DONE} state_t;

   // Handshake: req_valid is held by the requester until the one-cycle
   // resp_valid pulse; the memory holds mem_read/mem_write until mem_resp.
   state_t state;
   state_t state_next;

   logic                  lat_write;
   logic                  lat_byte;
   logic [ADDR_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0] lat_wdata;
   logic [LSB-1:0]        lane;
   logic [7:0]            lane_rdata;

   assign lane  = lat_addr[LSB-1:0];
   assign stall = req_valid & ~resp_valid;

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (req_valid) state_next = req_indirect ? PTR : ACCESS;
         PTR:     if (mem_resp)  state_next = ACCESS;
         ACCESS:  if (mem_resp)  state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      lane_rdata = 8'h00;
      for (int i = 0; i < BE_WIDTH; i++) begin
         if (lane == LSB'(i)) lane_rdata = mem_rdata[8*i +: 8];
      end
   end

   // Request fields are captured once in IDLE; the pointer phase overwrites
   // the address with the fetched pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         lat_write  <= 1'b0;
         lat_byte   <= 1'b0;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         resp_rdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  lat_write <= req_write;
                  lat_byte  <= req_byte;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
               end
            end
            PTR: begin
               if (mem_resp) lat_addr <= mem_rdata[ADDR_WIDTH-1:0];
            end
            ACCESS: begin
               if (mem_resp && !lat_write) begin
                  if (lat_byte) resp_rdata <= {{(DATA_WIDTH-8){1'b0}}, lane_rdata};
                  else          resp_rdata <= mem_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      mem_address     = '0;
      mem_byte_enable = '1;
      mem_wdata       = '0;
      resp_valid      = 1'b0;
      case (state)
         PTR: begin
            mem_read    = 1'b1;
            mem_address = lat_addr & ALIGN_MASK;
         end
         ACCESS: begin
            mem_read    = ~lat_write;
            mem_write   = lat_write;
            mem_address = lat_addr & ALIGN_MASK;
            if (lat_byte) begin
               mem_byte_enable = BE_WIDTH'(1) << lane;
               if (lat_write) begin
                  for (int i = 0; i < BE_WIDTH; i++) begin
                     if (lane == LSB'(i)) mem_wdata[8*i +: 8] = lat_wdata[7:0];
                  end
               end
            end else if (lat_write) begin
               mem_wdata = lat_wdata;
            end
         end
         DONE:    resp_valid = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed operations against a 16-bit and a
// 32-bit instance, with a memory responder and a queue-based reference model.
`timescale 1ns/1ps
module tb_mem_access_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        req_valid, req_write, req_byte, req_indirect;
   logic [15:0] req_addr, req_wdata;
   logic        resp_valid, stall;
   logic [15:0] resp_rdata;
   logic [15:0] mem_address, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, mem_resp;
   logic [1:0]  mem_byte_enable;

   logic        w_req_valid, w_req_write, w_req_byte, w_req_indirect;
   logic [15:0] w_req_addr;
   logic [31:0] w_req_wdata;
   logic        w_resp_valid, w_stall;
   logic [31:0] w_resp_rdata, w_mem_wdata, w_mem_rdata;
   logic [15:0] w_mem_address;
   logic        w_mem_read, w_mem_write, w_mem_resp;
   logic [3:0]  w_mem_byte_enable;

   mem_access_sequencer #(.DATA_WIDTH(16), .ADDR_WIDTH(16)) dut16 (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_write(req_write), .req_byte(req_byte),
      .req_indirect(req_indirect), .req_addr(req_addr), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_rdata(resp_rdata), .stall(stall),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_byte_enable(mem_byte_enable), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   mem_access_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut32 (
      .clk(clk), .rst(rst),
      .req_valid(w_req_valid), .req_write(w_req_write), .req_byte(w_req_byte),
      .req_indirect(w_req_indirect), .req_addr(w_req_addr), .req_wdata(w_req_wdata),
      .resp_valid(w_resp_valid), .resp_rdata(w_resp_rdata), .stall(w_stall),
      .mem_address(w_mem_address), .mem_read(w_mem_read), .mem_write(w_mem_write),
      .mem_byte_enable(w_mem_byte_enable), .mem_wdata(w_mem_wdata),
      .mem_rdata(w_mem_rdata), .mem_resp(w_mem_resp)
   );

   int tests = 0;
   int fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic fail_now(input string name);
      tests++;
      fails++;
      $display("FAIL %s at %0t", name, $time);
   endtask

   // Reference model: byte-lane arithmetic on plain integers.
   function automatic int m_lane(input logic [15:0] a, input int nb);
      return int'(a) % nb;
   endfunction
   function automatic logic [31:0] m_align(input logic [15:0] a, input int nb);
      return 32'(int'(a) - m_lane(a, nb));
   endfunction
   function automatic logic [31:0] m_be(input logic [15:0] a, input int nb, input logic b);
      return b ? 32'(1 << m_lane(a, nb)) : 32'((1 << nb) - 1);
   endfunction
   function automatic logic [31:0] m_wd(input logic [31:0] d, input logic [15:0] a, input int nb, input logic b);
      return b ? ((d & 32'hFF) << (8 * m_lane(a, nb))) : d;
   endfunction
   function automatic logic [31:0] m_rd(input logic [31:0] d, input logic [15:0] a, input int nb, input logic b);
      return b ? ((d >> (8 * m_lane(a, nb))) & 32'hFF) : d;
   endfunction

   typedef struct packed {
      logic        rd;
      logic        wr;
      logic [15:0] addr;
      logic [1:0]  be;
      logic [15:0] wdata;
   } acc_t;

   acc_t        acc_q[$];
   logic [15:0] res_q[$];
   int          dly_q[$];
   logic [15:0] dat_q[$];
   logic [15:0] model_rdata = 16'h0000;

   logic [15:0] act_addr, act_wdata;
   logic [1:0]  act_be;

   logic manual_mem = 1'b0;
   logic man_resp   = 1'b0;
   int   mem_cnt    = 0;

   // Memory responder: answers each strobed access after its queued delay.
   initial begin
      mem_resp  = 1'b0;
      mem_rdata = 16'h0000;
      forever begin
         @(posedge clk);
         #1;
         if (manual_mem) begin
            mem_resp = man_resp;
            mem_cnt  = 0;
         end else begin
            if (mem_resp) mem_cnt = 0;
            mem_resp = 1'b0;
            if (mem_read || mem_write) begin
               mem_cnt++;
               if (dly_q.size() > 0 && mem_cnt >= dly_q[0]) begin
                  mem_resp  = 1'b1;
                  mem_rdata = dat_q.pop_front();
                  void'(dly_q.pop_front());
               end
            end
         end
      end
   end

   // Compare process for the 16-bit instance.
   always @(negedge clk) begin
      if (!rst) begin
         check("stall", 32'(stall), 32'(req_valid & ~resp_valid));
         if (mem_read || mem_write) begin
            if (acc_q.size() == 0) begin
               fail_now("unexpected_strobe");
            end else begin
               check("mem_read", 32'(mem_read), 32'(acc_q[0].rd));
               check("mem_write", 32'(mem_write), 32'(acc_q[0].wr));
               check("mem_address", 32'(mem_address), 32'(acc_q[0].addr));
               check("mem_byte_enable", 32'(mem_byte_enable), 32'(acc_q[0].be));
               if (acc_q[0].wr) check("mem_wdata", 32'(mem_wdata), 32'(acc_q[0].wdata));
               if (mem_resp) begin
                  act_addr  = mem_address;
                  act_be    = mem_byte_enable;
                  act_wdata = mem_wdata;
                  void'(acc_q.pop_front());
               end
            end
         end
         if (resp_valid) begin
            if (res_q.size() == 0) fail_now("unexpected_resp_valid");
            else check("resp_rdata", 32'(resp_rdata), 32'(res_q.pop_front()));
         end
      end
   end

   task automatic op(input logic w, input logic b, input logic ind,
                     input logic [15:0] a, input logic [15:0] wd,
                     input int nptr, input logic [15:0] ptr,
                     input int nacc, input logic [15:0] rd,
                     input logic [15:0] lit_addr, input logic [1:0] lit_be,
                     input logic [15:0] lit_val);
      acc_t        e;
      logic [15:0] fa;
      int          k;
      int          lat;
      fa = a;
      if (ind) begin
         e.rd = 1'b1; e.wr = 1'b0; e.addr = 16'(m_align(a, 2)); e.be = 2'b11; e.wdata = 16'h0;
         acc_q.push_back(e);
         dly_q.push_back(nptr);
         dat_q.push_back(ptr);
         fa = ptr;
      end
      e.rd = ~w; e.wr = w;
      e.addr  = 16'(m_align(fa, 2));
      e.be    = 2'(m_be(fa, 2, b));
      e.wdata = 16'(m_wd(32'(wd), fa, 2, b));
      acc_q.push_back(e);
      dly_q.push_back(nacc);
      dat_q.push_back(rd);
      if (!w) model_rdata = 16'(m_rd(32'(rd), fa, 2, b));
      res_q.push_back(model_rdata);
      lat = 2 + nacc + (ind ? nptr : 0);

      @(posedge clk);
      #1;
      req_valid = 1'b1; req_write = w; req_byte = b; req_indirect = ind;
      req_addr = a; req_wdata = wd;
      k = 0;
      do begin
         @(negedge clk);
         k++;
         if (k == 2 && !resp_valid) begin
            req_addr     = 16'($urandom);
            req_wdata    = 16'($urandom);
            req_write    = ~w;
            req_byte     = ~b;
            req_indirect = ~ind;
         end
      end while (!resp_valid && k < 60);
      check("latency", 32'(k), 32'(lat));
      check("lit_addr", 32'(act_addr), 32'(lit_addr));
      check("lit_be", 32'(act_be), 32'(lit_be));
      if (w) check("lit_wdata", 32'(act_wdata), 32'(lit_val));
      else   check("lit_rdata", 32'(resp_rdata), 32'(lit_val));
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      @(negedge clk);
      check("stall_after", 32'(stall), 32'h0);
      check("resp_pulse", 32'(resp_valid), 32'h0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      acc_t e;
      int   k;
      req_valid = 0; req_write = 0; req_byte = 0; req_indirect = 0;
      req_addr = 0; req_wdata = 0;
      w_req_valid = 0; w_req_write = 0; w_req_byte = 0; w_req_indirect = 0;
      w_req_addr = 0; w_req_wdata = 0; w_mem_rdata = 0; w_mem_resp = 0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_rdata", 32'(resp_rdata), 32'h0);
      check("rst_mem_read", 32'(mem_read), 32'h0);
      check("rst_mem_write", 32'(mem_write), 32'h0);
      check("rst_mem_address", 32'(mem_address), 32'h0);
      check("rst_mem_be", 32'(mem_byte_enable), 32'h3);
      check("rst_mem_wdata", 32'(mem_wdata), 32'h0);
      check("rst_w_mem_be", 32'(w_mem_byte_enable), 32'hF);
      @(posedge clk);
      #1;
      rst = 1'b0;

      //  w  b  ind addr      wdata     nptr ptr       nacc rdata     lit_addr  be     lit_val
      op(0, 0, 0, 16'h1235, 16'h0000, 0,   16'h0000, 2,   16'hBEEF, 16'h1234, 2'b11, 16'hBEEF);
      op(1, 1, 0, 16'h0041, 16'h00A5, 0,   16'h0000, 1,   16'h0000, 16'h0040, 2'b10, 16'hA500);
      op(0, 1, 0, 16'h0041, 16'h0000, 0,   16'h0000, 3,   16'h7F33, 16'h0040, 2'b10, 16'h007F);
      op(0, 1, 0, 16'h0040, 16'h0000, 0,   16'h0000, 1,   16'h7F33, 16'h0040, 2'b01, 16'h0033);
      op(1, 1, 0, 16'h0040, 16'h12A5, 0,   16'h0000, 2,   16'h0000, 16'h0040, 2'b01, 16'h00A5);
      op(1, 0, 0, 16'h1001, 16'h5A5A, 0,   16'h0000, 1,   16'h0000, 16'h1000, 2'b11, 16'h5A5A);
      op(0, 0, 1, 16'h0100, 16'h0000, 2,   16'h3000, 1,   16'h1111, 16'h3000, 2'b11, 16'h1111);
      op(1, 0, 1, 16'h0100, 16'hCAFE, 1,   16'h2002, 2,   16'h0000, 16'h2002, 2'b11, 16'hCAFE);
      op(0, 1, 1, 16'h0201, 16'h0000, 3,   16'h4003, 2,   16'hAB00, 16'h4002, 2'b10, 16'h00AB);

      // Reset while the pointer read is outstanding; mem_resp arrives late.
      manual_mem = 1'b1;
      man_resp   = 1'b0;
      e.rd = 1'b1; e.wr = 1'b0; e.addr = 16'h0100; e.be = 2'b11; e.wdata = 16'h0;
      acc_q.push_back(e);
      @(posedge clk);
      #1;
      req_valid = 1'b1; req_write = 1'b0; req_byte = 1'b0; req_indirect = 1'b1;
      req_addr = 16'h0101;
      @(negedge clk);
      @(negedge clk);
      check("ptr_read_before_rst", 32'(mem_read), 32'h1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      req_valid = 1'b0;
      @(negedge clk);
      man_resp = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      man_resp = 1'b0;
      check("abort_mem_read", 32'(mem_read), 32'h0);
      check("abort_mem_write", 32'(mem_write), 32'h0);
      check("abort_mem_address", 32'(mem_address), 32'h0);
      check("abort_resp_rdata", 32'(resp_rdata), 32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("late_resp_no_strobe", 32'(mem_read | mem_write), 32'h0);
         check("late_resp_no_valid", 32'(resp_valid), 32'h0);
      end
      acc_q.delete();
      res_q.delete();
      dly_q.delete();
      dat_q.delete();
      model_rdata = 16'h0000;
      manual_mem  = 1'b0;
      op(0, 0, 0, 16'h0002, 16'h0000, 0,   16'h0000, 1,   16'h0F0F, 16'h0002, 2'b11, 16'h0F0F);

      // 32-bit instance: byte store to the top lane, then byte load from lane 2.
      @(posedge clk);
      #1;
      w_req_valid = 1'b1; w_req_write = 1'b1; w_req_byte = 1'b1; w_req_addr = 16'h0007;
      w_req_wdata = 32'h123456C3;
      @(negedge clk);
      @(negedge clk);
      check("w32_st_write", 32'(w_mem_write), 32'h1);
      check("w32_st_read", 32'(w_mem_read), 32'h0);
      check("w32_st_addr", 32'(w_mem_address), 32'h0004);
      check("w32_st_be", 32'(w_mem_byte_enable), 32'h8);
      check("w32_st_be_model", 32'(w_mem_byte_enable), m_be(16'h0007, 4, 1'b1));
      check("w32_st_wdata", w_mem_wdata, 32'hC3000000);
      check("w32_st_wdata_model", w_mem_wdata, m_wd(32'h123456C3, 16'h0007, 4, 1'b1));
      w_mem_resp = 1'b1;
      @(posedge clk);
      #1;
      w_mem_resp = 1'b0;
      @(negedge clk);
      check("w32_st_resp_valid", 32'(w_resp_valid), 32'h1);
      check("w32_st_resp_rdata", w_resp_rdata, 32'h0);
      @(posedge clk);
      #1;
      w_req_valid = 1'b0;
      @(negedge clk);
      check("w32_st_pulse", 32'(w_resp_valid), 32'h0);

      @(posedge clk);
      #1;
      w_req_valid = 1'b1; w_req_write = 1'b0; w_req_byte = 1'b1; w_req_addr = 16'h000A;
      @(negedge clk);
      @(negedge clk);
      check("w32_ld_read", 32'(w_mem_read), 32'h1);
      check("w32_ld_addr", 32'(w_mem_address), 32'h0008);
      check("w32_ld_be", 32'(w_mem_byte_enable), 32'h4);
      w_mem_rdata = 32'h11AB2233;
      w_mem_resp  = 1'b1;
      @(posedge clk);
      #1;
      w_mem_resp = 1'b0;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!w_resp_valid && k < 10);
      check("w32_ld_latency", 32'(k), 32'h1);
      check("w32_ld_rdata", w_resp_rdata, 32'h000000AB);
      check("w32_ld_rdata_model", w_resp_rdata, m_rd(32'h11AB2233, 16'h000A, 4, 1'b1));
      @(posedge clk);
      #1;
      w_req_valid = 1'b0;
      repeat (2) @(negedge clk);

      if (acc_q.size() != 0) fail_now("accesses_left_unserved");
      if (res_q.size() != 0) fail_now("responses_missing");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
